// File: rtl/dma_axi32_mem_slave.sv
// AXI3 memory slave for DMA regressions: byte-strobed 64-bit word array behind
// independent single-outstanding write and read burst engines (INCR only).
module dma_axi32_mem_slave #(
  parameter int ID_W   = 1,
  parameter int LEN_W  = 4,
  parameter int MEM_AW = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ID_W-1:0]  AWID,
  input  logic [31:0]      AWADDR,
  input  logic [LEN_W-1:0] AWLEN,
  input  logic [1:0]       AWSIZE,
  input  logic             AWVALID,
  output logic             AWREADY,
  input  logic [ID_W-1:0]  WID,
  input  logic [63:0]      WDATA,
  input  logic [7:0]       WSTRB,
  input  logic             WLAST,
  input  logic             WVALID,
  output logic             WREADY,
  output logic [ID_W-1:0]  BID,
  output logic [1:0]       BRESP,
  output logic             BVALID,
  input  logic             BREADY,
  input  logic [ID_W-1:0]  ARID,
  input  logic [31:0]      ARADDR,
  input  logic [LEN_W-1:0] ARLEN,
  input  logic [1:0]       ARSIZE,
  input  logic             ARVALID,
  output logic             ARREADY,
  output logic [ID_W-1:0]  RID,
  output logic [63:0]      RDATA,
  output logic [1:0]       RRESP,
  output logic             RLAST,
  output logic             RVALID,
  input  logic             RREADY
);
  localparam int MEM_DEPTH = 2 ** MEM_AW;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  // Align down to the beat size, then step one beat; wraps naturally at 2^32.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] size);
    logic [31:0] step;
    step = 32'd1 << size;
    return (addr & ~(step - 32'd1)) + step;
  endfunction

  function automatic logic addr_ok(input logic [31:0] addr);
    return (addr >> (MEM_AW + 3)) == 32'd0;
  endfunction

  logic [63:0] mem_r [MEM_DEPTH];

  w_state_t         w_state_r, w_state_nxt_s;
  logic             awready_r, awready_nxt_s, wready_r, wready_nxt_s, bvalid_r, bvalid_nxt_s;
  logic [ID_W-1:0]  bid_r, bid_nxt_s;
  logic [1:0]       bresp_r, bresp_nxt_s;
  logic [31:0]      waddr_r, waddr_nxt_s;
  logic [LEN_W-1:0] wlen_r, wlen_nxt_s, wcnt_r, wcnt_nxt_s;
  logic [1:0]       wsize_r, wsize_nxt_s;
  logic             werr_r, werr_nxt_s, w_beat_err_s, mem_we_s;

  r_state_t         r_state_r, r_state_nxt_s;
  logic             arready_r, arready_nxt_s, rvalid_r, rvalid_nxt_s, rlast_r, rlast_nxt_s;
  logic [ID_W-1:0]  rid_r, rid_nxt_s;
  logic [63:0]      rdata_r, rdata_nxt_s, fetch_data_s;
  logic [1:0]       rresp_r, rresp_nxt_s, fetch_resp_s;
  logic [31:0]      raddr_r, raddr_nxt_s, fetch_addr_s;
  logic [LEN_W-1:0] rlen_r, rlen_nxt_s, rcnt_r, rcnt_nxt_s;
  logic [1:0]       rsize_r, rsize_nxt_s;
  logic             unused_wid_s;

  assign unused_wid_s = ^WID;
  assign w_beat_err_s = !addr_ok(waddr_r) || (WLAST != (wcnt_r == wlen_r));

  // Write engine: next-state and next register values.
  always_comb begin
    w_state_nxt_s = w_state_r;
    awready_nxt_s = awready_r;
    wready_nxt_s  = wready_r;
    bvalid_nxt_s  = bvalid_r;
    bid_nxt_s     = bid_r;
    bresp_nxt_s   = bresp_r;
    waddr_nxt_s   = waddr_r;
    wlen_nxt_s    = wlen_r;
    wsize_nxt_s   = wsize_r;
    wcnt_nxt_s    = wcnt_r;
    werr_nxt_s    = werr_r;
    mem_we_s      = 1'b0;
    case (w_state_r)
      W_IDLE: begin
        if (AWVALID && awready_r) begin
          w_state_nxt_s = W_DATA;
          awready_nxt_s = 1'b0;
          wready_nxt_s  = 1'b1;
          bid_nxt_s     = AWID;
          waddr_nxt_s   = AWADDR;
          wlen_nxt_s    = AWLEN;
          wsize_nxt_s   = AWSIZE;
          wcnt_nxt_s    = '0;
          werr_nxt_s    = 1'b0;
        end else begin
          awready_nxt_s = 1'b1;
        end
      end
      W_DATA: begin
        if (WVALID && wready_r) begin
          mem_we_s    = addr_ok(waddr_r);
          werr_nxt_s  = werr_r | w_beat_err_s;
          waddr_nxt_s = next_addr(waddr_r, wsize_r);
          wcnt_nxt_s  = wcnt_r + LEN_W'(1);
          if (wcnt_r == wlen_r) begin
            w_state_nxt_s = W_RESP;
            wready_nxt_s  = 1'b0;
            bvalid_nxt_s  = 1'b1;
            bresp_nxt_s   = (werr_r | w_beat_err_s) ? 2'b10 : 2'b00;
          end else begin
            w_state_nxt_s = W_DATA;
          end
        end else begin
          w_state_nxt_s = W_DATA;
        end
      end
      W_RESP: begin
        if (BREADY) begin
          w_state_nxt_s = W_IDLE;
          bvalid_nxt_s  = 1'b0;
          awready_nxt_s = 1'b1;
        end else begin
          w_state_nxt_s = W_RESP;
        end
      end
      default: begin
        w_state_nxt_s = W_IDLE;
      end
    endcase
  end

  // The beat presented next is either the first (from AR) or the running burst address.
  assign fetch_addr_s = (r_state_r == R_IDLE) ? ARADDR : raddr_r;
  assign fetch_data_s = addr_ok(fetch_addr_s) ? mem_r[fetch_addr_s[MEM_AW+2:3]] : 64'd0;
  assign fetch_resp_s = addr_ok(fetch_addr_s) ? 2'b00 : 2'b10;

  // Read engine: next-state and next register values.
  always_comb begin
    r_state_nxt_s = r_state_r;
    arready_nxt_s = arready_r;
    rvalid_nxt_s  = rvalid_r;
    rlast_nxt_s   = rlast_r;
    rid_nxt_s     = rid_r;
    rdata_nxt_s   = rdata_r;
    rresp_nxt_s   = rresp_r;
    raddr_nxt_s   = raddr_r;
    rlen_nxt_s    = rlen_r;
    rsize_nxt_s   = rsize_r;
    rcnt_nxt_s    = rcnt_r;
    case (r_state_r)
      R_IDLE: begin
        if (ARVALID && arready_r) begin
          r_state_nxt_s = R_DATA;
          arready_nxt_s = 1'b0;
          rvalid_nxt_s  = 1'b1;
          rid_nxt_s     = ARID;
          rlen_nxt_s    = ARLEN;
          rsize_nxt_s   = ARSIZE;
          rcnt_nxt_s    = '0;
          rlast_nxt_s   = (ARLEN == '0);
          rdata_nxt_s   = fetch_data_s;
          rresp_nxt_s   = fetch_resp_s;
          raddr_nxt_s   = next_addr(ARADDR, ARSIZE);
        end else begin
          arready_nxt_s = 1'b1;
        end
      end
      R_DATA: begin
        if (rvalid_r && RREADY) begin
          if (rcnt_r == rlen_r) begin
            r_state_nxt_s = R_IDLE;
            rvalid_nxt_s  = 1'b0;
            rlast_nxt_s   = 1'b0;
            arready_nxt_s = 1'b1;
          end else begin
            rcnt_nxt_s  = rcnt_r + LEN_W'(1);
            rlast_nxt_s = ((rcnt_r + LEN_W'(1)) == rlen_r);
            rdata_nxt_s = fetch_data_s;
            rresp_nxt_s = fetch_resp_s;
            raddr_nxt_s = next_addr(raddr_r, rsize_r);
          end
        end else begin
          r_state_nxt_s = R_DATA;
        end
      end
      default: begin
        r_state_nxt_s = R_IDLE;
      end
    endcase
  end

  // State and output registers for both engines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state_r <= W_IDLE;  awready_r <= 1'b0;  wready_r <= 1'b0;  bvalid_r <= 1'b0;
      bid_r     <= '0;      bresp_r   <= 2'b00; waddr_r  <= 32'd0; wlen_r   <= '0;
      wsize_r   <= 2'b00;   wcnt_r    <= '0;    werr_r   <= 1'b0;
      r_state_r <= R_IDLE;  arready_r <= 1'b0;  rvalid_r <= 1'b0;  rlast_r  <= 1'b0;
      rid_r     <= '0;      rdata_r   <= 64'd0; rresp_r  <= 2'b00; raddr_r  <= 32'd0;
      rlen_r    <= '0;      rsize_r   <= 2'b00; rcnt_r   <= '0;
    end else begin
      w_state_r <= w_state_nxt_s; awready_r <= awready_nxt_s; wready_r <= wready_nxt_s;
      bvalid_r  <= bvalid_nxt_s;  bid_r     <= bid_nxt_s;     bresp_r  <= bresp_nxt_s;
      waddr_r   <= waddr_nxt_s;   wlen_r    <= wlen_nxt_s;    wsize_r  <= wsize_nxt_s;
      wcnt_r    <= wcnt_nxt_s;    werr_r    <= werr_nxt_s;
      r_state_r <= r_state_nxt_s; arready_r <= arready_nxt_s; rvalid_r <= rvalid_nxt_s;
      rlast_r   <= rlast_nxt_s;   rid_r     <= rid_nxt_s;     rdata_r  <= rdata_nxt_s;
      rresp_r   <= rresp_nxt_s;   raddr_r   <= raddr_nxt_s;   rlen_r   <= rlen_nxt_s;
      rsize_r   <= rsize_nxt_s;   rcnt_r    <= rcnt_nxt_s;
    end
  end

  // Byte-strobed word writes; contents survive reset. Lanes are never repositioned.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int b = 0; b < 8; b++) begin
        if (WSTRB[b]) begin
          mem_r[waddr_r[MEM_AW+2:3]][8*b +: 8] <= WDATA[8*b +: 8];
        end
      end
    end
  end

  assign AWREADY = awready_r;
  assign WREADY  = wready_r;
  assign BVALID  = bvalid_r;
  assign BID     = bid_r;
  assign BRESP   = bresp_r;
  assign ARREADY = arready_r;
  assign RVALID  = rvalid_r;
  assign RLAST   = rlast_r;
  assign RID     = rid_r;
  assign RDATA   = rdata_r;
  assign RRESP   = rresp_r;

endmodule

// File: tb/tb_dma_axi32_mem_slave.sv
// Directed bench for dma_axi32_mem_slave: byte-addressed memory model plus
// expected-response queues, checked every cycle by one compare process.
module tb_dma_axi32_mem_slave;
  localparam logic [31:0] MEM_BYTES = 32'd8192;

  logic        clk = 1'b0;
  logic        reset;
  logic        AWID, WID, BID, ARID, RID;
  logic [31:0] AWADDR, ARADDR;
  logic [3:0]  AWLEN, ARLEN;
  logic [1:0]  AWSIZE, ARSIZE, BRESP, RRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [63:0] WDATA, RDATA;
  logic [7:0]  WSTRB;

  dma_axi32_mem_slave dut (
    .clk(clk), .reset(reset),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 clk = ~clk;

  typedef struct {logic [63:0] d; logic [1:0] resp; logic last; logic id;} rbeat_t;
  typedef struct {logic id; logic [1:0] resp;} bresp_t;

  logic [7:0]  mmem [8192];
  rbeat_t      exp_r[$];
  bresp_t      exp_b[$];
  logic [63:0] got_r[$];
  logic [1:0]  got_rresp[$];
  logic        last_bid;
  logic [1:0]  last_bresp;
  logic [63:0] wdat [16];
  logic [7:0]  wstb [16];
  logic [15:0] wlast_m;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] step_addr(input logic [31:0] a, input logic [1:0] size);
    return ((a >> size) + 32'd1) << size;
  endfunction

  task automatic write_burst(input logic id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [1:0] size);
    logic [31:0] a;
    logic err;
    int to;
    a = addr;
    err = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (a < MEM_BYTES) begin
        for (int b = 0; b < 8; b++)
          if (wstb[i][b]) mmem[int'(a / 8) * 8 + b] = wdat[i][8*b +: 8];
      end else begin
        err = 1'b1;
      end
      if (wlast_m[i] != (i == int'(len))) err = 1'b1;
      a = step_addr(a, size);
    end
    exp_b.push_back('{id: id, resp: (err ? 2'b10 : 2'b00)});
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWVALID = 1'b1;
    to = 0;
    @(negedge clk);
    while (!AWREADY && to < 50) begin @(negedge clk); to++; end
    check("aw_ready", AWREADY, 1);
    @(posedge clk); #1;
    AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      WDATA = wdat[i]; WSTRB = wstb[i]; WLAST = wlast_m[i]; WVALID = 1'b1;
      to = 0;
      @(negedge clk);
      while (!WREADY && to < 50) begin @(negedge clk); to++; end
      check("w_ready", WREADY, 1);
      @(posedge clk); #1;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    @(negedge clk);
    check("b_latency", BVALID, 1);
    @(posedge clk); #1;
  endtask

  task automatic issue_ar(input logic id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] size);
    logic [31:0] a;
    rbeat_t e;
    int to;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      e.id = id;
      e.last = (i == int'(len));
      if (a < MEM_BYTES) begin
        e.resp = 2'b00;
        for (int b = 0; b < 8; b++) e.d[8*b +: 8] = mmem[int'(a / 8) * 8 + b];
      end else begin
        e.resp = 2'b10;
        e.d = 64'd0;
      end
      exp_r.push_back(e);
      a = step_addr(a, size);
    end
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARVALID = 1'b1;
    to = 0;
    @(negedge clk);
    while (!ARREADY && to < 50) begin @(negedge clk); to++; end
    check("ar_ready", ARREADY, 1);
    @(posedge clk); #1;
    ARVALID = 1'b0;
    @(negedge clk);
    check("r_latency", RVALID, 1);
  endtask

  task automatic wait_r_done();
    int to;
    to = 0;
    while (exp_r.size() != 0 && to < 100) begin @(negedge clk); to++; end
    check("r_drain", (exp_r.size() == 0), 1);
    @(posedge clk); #1;
  endtask

  // Compare process: every accepted R beat and B response against the model queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (RVALID && RREADY) begin
        if (exp_r.size() == 0) begin
          check("r_unexpected", RVALID, 0);
        end else begin
          rbeat_t e;
          e = exp_r.pop_front();
          check("rdata", RDATA, e.d);
          check("rresp", RRESP, e.resp);
          check("rlast", RLAST, e.last);
          check("rid", RID, e.id);
          got_r.push_back(RDATA);
          got_rresp.push_back(RRESP);
        end
      end
      if (BVALID && BREADY) begin
        if (exp_b.size() == 0) begin
          check("b_unexpected", BVALID, 0);
        end else begin
          bresp_t e;
          e = exp_b.pop_front();
          check("bid", BID, e.id);
          check("bresp", BRESP, e.resp);
          last_bid = BID;
          last_bresp = BRESP;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] s_data;
    logic [1:0]  s_resp;
    logic        s_last;
    reset = 1'b1;
    AWID = 1'b0; AWADDR = 32'd0; AWLEN = 4'd0; AWSIZE = 2'd0; AWVALID = 1'b0;
    WID = 1'b0; WDATA = 64'd0; WSTRB = 8'd0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
    ARID = 1'b0; ARADDR = 32'd0; ARLEN = 4'd0; ARSIZE = 2'd0; ARVALID = 1'b0; RREADY = 1'b1;
    last_bid = 1'b0; last_bresp = 2'b00;
    for (int i = 0; i < 8192; i++) mmem[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", AWREADY, 0);
    check("rst_arready", ARREADY, 0);
    check("rst_outs", {WREADY, BVALID, RVALID, RLAST, BID, RID, BRESP, RRESP}, 0);
    check("rst_rdata", RDATA, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rel_awready_0", AWREADY, 0);
    @(negedge clk);
    check("rel_awready_1", AWREADY, 1);
    check("rel_arready_1", ARREADY, 1);
    @(posedge clk); #1;

    // single beat write then read back
    wdat[0] = 64'h1122334455667788; wstb[0] = 8'hFF; wlast_m = 16'h0001;
    write_burst(1'b1, 32'h40, 4'd0, 2'd3);
    check("t1_bid", last_bid, 1);
    check("t1_bresp", last_bresp, 2'b00);
    got_r.delete(); got_rresp.delete();
    issue_ar(1'b1, 32'h40, 4'd0, 2'd3);
    wait_r_done();
    check("t1_count", got_r.size(), 1);
    check("t1_rdata", got_r[0], 64'h1122334455667788);

    // 4-beat burst, overwritten with a partial strobe on beat 2
    for (int i = 0; i < 4; i++) begin wdat[i] = 64'hAAAAAAAAAAAAAAAA; wstb[i] = 8'hFF; end
    wlast_m = 16'h0008;
    write_burst(1'b0, 32'h100, 4'd3, 2'd3);
    for (int i = 0; i < 4; i++) wdat[i] = 64'h5555555555555555;
    wstb[1] = 8'h0F;
    write_burst(1'b0, 32'h100, 4'd3, 2'd3);
    got_r.delete(); got_rresp.delete();
    issue_ar(1'b0, 32'h100, 4'd3, 2'd3);
    wait_r_done();
    check("t2_count", got_r.size(), 4);
    check("t2_beat1", got_r[0], 64'h5555555555555555);
    check("t2_beat2", got_r[1], 64'hAAAAAAAA55555555);
    check("t2_beat3", got_r[2], 64'h5555555555555555);
    check("t2_beat4", got_r[3], 64'h5555555555555555);

    // back-pressure: outputs held while RREADY is low
    RREADY = 1'b0;
    got_r.delete(); got_rresp.delete();
    issue_ar(1'b1, 32'h100, 4'd3, 2'd3);
    s_data = RDATA; s_resp = RRESP; s_last = RLAST;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_rvalid", RVALID, 1);
      check("stall_rdata", RDATA, s_data);
      check("stall_rlast_rresp", {RLAST, RRESP}, {s_last, s_resp});
    end
    @(posedge clk); #1;
    RREADY = 1'b1;
    wait_r_done();
    check("t3_count", got_r.size(), 4);
    check("t3_beat2", got_r[1], 64'hAAAAAAAA55555555);

    // out-of-range write and read
    wdat[0] = 64'hDEADBEEFCAFEF00D; wstb[0] = 8'hFF; wlast_m = 16'h0001;
    write_burst(1'b0, 32'h0, 4'd0, 2'd3);
    wdat[0] = 64'h0123456789ABCDEF;
    write_burst(1'b0, MEM_BYTES - 32'd8, 4'd0, 2'd3);
    wdat[0] = 64'hFFFFFFFFFFFFFFFF;
    write_burst(1'b1, MEM_BYTES, 4'd0, 2'd3);
    check("t4_oob_bresp", last_bresp, 2'b10);
    got_r.delete(); got_rresp.delete();
    issue_ar(1'b0, 32'h0, 4'd0, 2'd3);
    wait_r_done();
    check("t4_word0_kept", got_r[0], 64'hDEADBEEFCAFEF00D);
    got_r.delete(); got_rresp.delete();
    issue_ar(1'b0, MEM_BYTES - 32'd8, 4'd1, 2'd3);
    wait_r_done();
    check("t4_count", got_r.size(), 2);
    check("t4_beat1", {got_rresp[0], got_r[0]}, {2'b00, 64'h0123456789ABCDEF});
    check("t4_beat2", {got_rresp[1], got_r[1]}, {2'b10, 64'd0});

    // early WLAST: all four beats still taken, error reported
    for (int i = 0; i < 4; i++) begin wdat[i] = 64'h0F0F0F0F00000000 + 64'(i); wstb[i] = 8'hFF; end
    wlast_m = 16'h0002;
    write_burst(1'b1, 32'h200, 4'd3, 2'd3);
    check("t5_bresp", last_bresp, 2'b10);

    // reset in the middle of a read burst
    got_r.delete(); got_rresp.delete();
    issue_ar(1'b1, 32'h100, 4'd3, 2'd3);
    @(posedge clk); #1;
    check("t6_beat2_valid", RVALID, 1);
    reset = 1'b1;
    #1;
    exp_r.delete();
    check("t6_rst_rvalid", RVALID, 0);
    check("t6_rst_arready", ARREADY, 0);
    check("t6_rst_rdata", {RLAST, RDATA}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t6_arready_0", ARREADY, 0);
    @(negedge clk);
    check("t6_arready_1", ARREADY, 1);
    @(posedge clk); #1;
    got_r.delete(); got_rresp.delete();
    issue_ar(1'b0, 32'h40, 4'd0, 2'd3);
    wait_r_done();
    check("t6_new_burst", {got_rresp[0], got_r[0]}, {2'b00, 64'h1122334455667788});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
